pc_unit: RTL and testbench
==========================

// Module: pc_unit
// PURPOSE
//  Program-counter unit for the fetch stage: holds the architectural PC and computes the next PC.
//  - Default next PC: sequential increment PC+INC.
//  - Accepts branch/jump redirects from execute.
//  - Holds the PC under pipeline stall.
//  - A redirect arriving during a stall is buffered and applied once the stall releases.
//  Generalises the fixed 32-bit PC+4 adder in width, increment and reset vector.
// PARAMETERS
//  XLEN          32        PC / target width in bits
//  INC           4         sequential increment in bytes; only 2 or 4 legal (elaboration $error otherwise)
//  RESET_VECTOR  32'h0     PC value loaded on reset (XLEN bits)
//  TRAP_VECTOR   32'h100   PC loaded on misaligned redirect (used only with PC_MISALIGN_TRAP_EN)
// PORTS
//  clk                 in   1     clock, rising edge
//  rst                 in   1     synchronous reset, active-high
//  stall_i             in   1     1 = hold PC this cycle
//  redirect_i          in   1     1 = target_i is a taken branch/jump target
//  target_i            in   XLEN  redirect target address
//  pc_o                out  XLEN  current PC (registered)
//  pc_plus_o           out  XLEN  pc_o + INC (combinational, link value)
//  redirect_pending_o  out  1     1 = buffered redirect awaiting stall release (registered)
//  misalign_o          out  1     1-cycle pulse: misaligned target trapped (registered)
// BEHAVIOUR
//  Reset (rst=1 at clk edge, overrides all other inputs):
//  - pc_o=RESET_VECTOR; redirect_pending_o=0; pending target reg=0; misalign_o=0.
//  Per-edge priority when rst=0:
//  - stall_i=1: pc_o holds.
//    - If redirect_i=1, latch target_i into the pending reg and set redirect_pending_o=1.
//    - A later redirect during the same stall overwrites the pending reg (newest wins).
//  - stall_i=0, redirect_i=1: pc_o<=target_i; pending cleared.
//    - The live redirect beats any buffered one.
//  - stall_i=0, redirect_i=0, pending=1: pc_o<=pending target; pending cleared.
//  - Otherwise: pc_o<=pc_o+INC.
//  Latency:
//  - A redirect is visible on pc_o exactly one edge after acceptance (unstalled).
//  - A buffered redirect is visible on the first edge with stall_i=0.
//  Arithmetic:
//  - Increment is modulo 2^XLEN; carry out discarded.
//  - Example: 0xFFFF_FFFC+4 -> 0x0000_0000 (INC=4, XLEN=32).
//  pc_plus_o: pure combinational function of pc_o; same wrap rule.
//  Misaligned target: target with any of the low log2(INC) bits nonzero.
//  - Applies to both live and buffered targets, checked when loaded into pc_o.
//  Reset mid-operation: pending redirect discarded; resume from RESET_VECTOR.
//  No X propagation: pending reg always written with defined data under reset.
// CONFIGURATION
//  PC_MISALIGN_TRAP_EN defined:
//  - Loading a misaligned target sets pc_o<=TRAP_VECTOR instead of the target.
//  - misalign_o=1 for exactly that one cycle, then 0.
//  - Aligned targets unaffected.
//  PC_MISALIGN_TRAP_EN undefined:
//  - Targets are loaded verbatim.
//  - misalign_o tied to constant 0; TRAP_VECTOR unused.
// TESTING (XLEN=32, INC=4, RESET_VECTOR=0, TRAP_VECTOR=0x100)
//  1 Reset: rst=1 for 2 cycles -> pc_o=0x0, pc_plus_o=0x4, redirect_pending_o=0, misalign_o=0.
//  2 Free run: 3 edges, no stall/redirect -> pc_o 0x4, 0x8, 0xC.
//  3 Wrap: redirect 0xFFFF_FFFC, then 1 free edge -> pc_o=0x0000_0000, pc_plus_o=0x4.
//  4 Stalled redirect: pc_o=0x10; stall+redirect 0x200 for 1 edge; stall only for 2 edges
//    -> pc_o=0x10, pending=1; stall drop -> pc_o=0x200, pending=0.
//  5 Collision: pending=0x200; stall=0 with redirect 0x300 -> pc_o=0x300, pending=0.
//    Rst with pending=1 -> pending=0, pc_o=0x0.
//  6 Misalign: redirect 0x102.
//    - Macro on: pc_o=0x100, misalign_o=1 one cycle.
//    - Macro off: pc_o=0x102, misalign_o=0.

Source files
------------

// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit -- fetch-stage program counter
//
// Holds the architectural PC and selects the next PC each rising clock edge:
//   reset             -> RESET_VECTOR
//   stall             -> hold PC; a redirect is captured into a pending buffer
//                        (the newest redirect overwrites the buffer)
//   live redirect     -> target_i (beats any buffered redirect)
//   buffered redirect -> pending target, applied on the first unstalled edge
//   otherwise         -> PC + INC (modulo 2^XLEN)
//
// Optional feature (macro PC_MISALIGN_TRAP_EN):
//   A loaded target whose low log2(INC) bits are nonzero sends the PC to
//   TRAP_VECTOR, and misalign_o pulses for one cycle. Without the macro,
//   targets load verbatim and misalign_o is constant 0.
//
// Parameters:
//   XLEN          PC / target width in bits
//   INC           sequential increment in bytes (2 or 4 only)
//   RESET_VECTOR  PC after reset
//   TRAP_VECTOR   PC loaded on a misaligned target (trap build only)
//
// Ports:
//   clk                 in   clock, rising edge
//   rst                 in   synchronous reset, active-high
//   stall_i             in   hold PC this cycle
//   redirect_i          in   target_i is a taken branch/jump target
//   target_i            in   redirect target address
//   pc_o                out  current PC (registered)
//   pc_plus_o           out  pc_o + INC (combinational link value)
//   redirect_pending_o  out  buffered redirect awaiting stall release
//   misalign_o          out  one-cycle pulse: misaligned target trapped
// ---------------------------------------------------------------------------
module pc_unit #(
  parameter int              XLEN         = 32,
  parameter int              INC          = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h100
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] target_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus_o,
  output logic            redirect_pending_o,
  output logic            misalign_o
);

  // Only halfword and word fetch granules are meaningful.
  if (INC != 2 && INC != 4) begin : g_bad_inc
    $error("pc_unit: INC must be 2 or 4");
  end

  localparam logic [XLEN-1:0] INC_V      = XLEN'(INC);
  // Low address bits that must be zero for an aligned target.
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INC - 1);

`ifdef PC_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic [XLEN-1:0] pc_q,       pc_d;
  logic            pend_q,     pend_d;
  logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
  logic            misalign_d;

  logic            load;
  logic [XLEN-1:0] load_tgt;
  logic            load_misaligned;

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    pc_d       = pc_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    load       = 1'b0;
    load_tgt   = target_i;

    if (stall_i) begin
      // PC holds; newest redirect seen during the stall wins the buffer.
      if (redirect_i) begin
        pend_d     = 1'b1;
        pend_tgt_d = target_i;
      end
    end else if (redirect_i) begin
      load     = 1'b1;
      load_tgt = target_i;
      pend_d   = 1'b0;
    end else if (pend_q) begin
      load     = 1'b1;
      load_tgt = pend_tgt_q;
      pend_d   = 1'b0;
    end else begin
      pc_d = pc_q + INC_V;  // carry out dropped: wraps modulo 2^XLEN
    end

    load_misaligned = |(load_tgt & ALIGN_MASK);
    misalign_d      = 1'b0;
    if (load) begin
      if (TRAP_EN && load_misaligned) begin
        pc_d       = TRAP_VECTOR;
        misalign_d = 1'b1;
      end else begin
        pc_d = load_tgt;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_VECTOR;
      pend_q     <= 1'b0;
      // NOTE: the target buffer is reset too (not just its valid bit) so it
      // never holds X, even though pend_q alone gates its use.
      pend_tgt_q <= '0;
    end else begin
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  logic misalign_q;

  always_ff @(posedge clk) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= misalign_d;
  end

  assign misalign_o = misalign_q;
`else
  // misalign_d is always 0 here; the trap path is compiled out.
  logic unused_misalign;
  assign unused_misalign = misalign_d;
  assign misalign_o      = 1'b0;
`endif

  assign pc_o               = pc_q;
  assign pc_plus_o          = pc_q + INC_V;
  assign redirect_pending_o = pend_q;

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] target_i;
  logic [31:0] pc_o;
  logic [31:0] pc_plus_o;
  logic        redirect_pending_o;
  logic        misalign_o;

  pc_unit #(
    .XLEN(32), .INC(4), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h100)
  ) dut (
    .clk(clk),
    .rst(rst),
    .stall_i(stall_i),
    .redirect_i(redirect_i),
    .target_i(target_i),
    .pc_o(pc_o),
    .pc_plus_o(pc_plus_o),
    .redirect_pending_o(redirect_pending_o),
    .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

`ifdef PC_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: architectural PC, a one-deep "pending redirect" slot,
  // and the trap flag, advanced from the rules using plain integer arithmetic.
  longint unsigned m_pc;
  bit              m_pend;
  longint unsigned m_ptgt;
  bit              m_mis;
  bit              cmp_en = 1'b0;

  function automatic void m_load(input longint unsigned t);
    if (TRAP && (t % 4) != 0) begin
      m_pc  = 64'h100;
      m_mis = 1'b1;
    end else begin
      m_pc = t;
    end
  endfunction

  function automatic void m_step(input bit r, input bit s, input bit rd,
                                 input longint unsigned t);
    m_mis = 1'b0;
    if (r) begin
      m_pc = 0; m_pend = 0; m_ptgt = 0;
    end else if (s) begin
      if (rd) begin m_pend = 1; m_ptgt = t; end
    end else if (rd) begin
      m_load(t); m_pend = 0;
    end else if (m_pend) begin
      m_load(m_ptgt); m_pend = 0;
    end else begin
      m_pc = (m_pc + 4) % (64'd1 << 32);
    end
  endfunction

  // One clock: drive inputs, take the edge, advance the model.
  task automatic cyc(input bit r, input bit s, input bit rd, input logic [31:0] t);
    rst = r; stall_i = s; redirect_i = rd; target_i = t;
    @(posedge clk);
    m_step(r, s, rd, {32'h0, t});
    cmp_en = 1'b1;
    #2;
  endtask

  // Compare process: every cycle, mid-period, DUT against model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("model pc_o",      pc_o,      m_pc[31:0]);
      check("model pc_plus_o", pc_plus_o, 32'((m_pc + 4) % (64'd1 << 32)));
      check("model pending",   {31'h0, redirect_pending_o}, {31'h0, m_pend});
      check("model misalign",  {31'h0, misalign_o},         {31'h0, m_mis});
    end
  end

  initial begin
    rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; target_i = '0;
    #1;

    // 1 reset
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    check("reset pc",       pc_o,      32'h0);
    check("reset pc_plus",  pc_plus_o, 32'h4);
    check("reset pending",  {31'h0, redirect_pending_o}, 32'h0);
    check("reset misalign", {31'h0, misalign_o},         32'h0);

    // 2 free run
    cyc(0, 0, 0, 0); check("run pc 1", pc_o, 32'h4);
    cyc(0, 0, 0, 0); check("run pc 2", pc_o, 32'h8);
    cyc(0, 0, 0, 0); check("run pc 3", pc_o, 32'hC);

    // 3 wrap
    cyc(0, 0, 1, 32'hFFFF_FFFC); check("wrap tgt", pc_o, 32'hFFFF_FFFC);
    check("wrap plus at top", pc_plus_o, 32'h0);
    cyc(0, 0, 0, 0);
    check("wrap pc",   pc_o,      32'h0);
    check("wrap plus", pc_plus_o, 32'h4);

    // 4 stalled redirect
    repeat (4) cyc(0, 0, 0, 0);
    check("pre-stall pc", pc_o, 32'h10);
    cyc(0, 1, 1, 32'h200);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    check("stall pc",      pc_o, 32'h10);
    check("stall pending", {31'h0, redirect_pending_o}, 32'h1);
    cyc(0, 0, 0, 0);
    check("release pc",      pc_o, 32'h200);
    check("release pending", {31'h0, redirect_pending_o}, 32'h0);

    // 5 collision: live redirect beats buffered one
    cyc(0, 1, 1, 32'h200);
    check("coll pending set", {31'h0, redirect_pending_o}, 32'h1);
    cyc(0, 0, 1, 32'h300);
    check("coll pc",      pc_o, 32'h300);
    check("coll pending", {31'h0, redirect_pending_o}, 32'h0);
    // newest buffered redirect wins
    cyc(0, 1, 1, 32'h500);
    cyc(0, 1, 1, 32'h600);
    cyc(0, 0, 0, 0);
    check("newest wins", pc_o, 32'h600);
    // reset discards pending redirect
    cyc(0, 1, 1, 32'h400);
    cyc(1, 0, 0, 0);
    check("rst pending", {31'h0, redirect_pending_o}, 32'h0);
    check("rst pc",      pc_o, 32'h0);
    cyc(0, 0, 0, 0);
    check("rst resume", pc_o, 32'h4);

    // 6 misaligned redirect
    cyc(0, 0, 1, 32'h102);
    if (TRAP) begin
      check("mis pc",    pc_o, 32'h100);
      check("mis pulse", {31'h0, misalign_o}, 32'h1);
      cyc(0, 0, 0, 0);
      check("mis pulse end", {31'h0, misalign_o}, 32'h0);
      check("mis next pc",   pc_o, 32'h104);
    end else begin
      check("mis pc",    pc_o, 32'h102);
      check("mis pulse", {31'h0, misalign_o}, 32'h0);
      cyc(0, 0, 0, 0);
      check("mis next pc", pc_o, 32'h106);
    end

    // Randomized phase against the model
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] t;
      bit r, s, rd;
      r  = ($urandom_range(99) < 2);
      s  = ($urandom_range(99) < 35);
      rd = ($urandom_range(99) < 30);
      case ($urandom_range(3))
        0:       t = 32'hFFFF_FFF0 | ($urandom & 32'hC);
        1:       t = $urandom;                       // often misaligned
        default: t = $urandom & 32'hFFFF_FFFC;
      endcase
      cyc(r, s, rd, t);
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
